hsst2ad_fifo_wr_arb: RTL
========================

# hsst2ad_fifo_wr_arb

Packet-granular round-robin arbiter that shares the single write port of the synchronous `hsst2ad` FIFO (`ipml_fifo_v1_6_hsst2ad`, `c_FIFO_TYPE="SYN"`) among several HSST lane requesters.
- Each requester sends framed packets as valid/ready beats.
- The arbiter grants one requester for a whole packet and tags every beat with source ID and last flag.
- It throttles on FIFO full and almost-full, and truncates runaway packets at a maximum length.
- It sits between the HSST lane deframers and the FIFO write side, in the FIFO's write clock domain.

## Interface
Parameters:
- `c_NUM_REQ`, 4, number of requesters (2–8).
- `c_DATA_WIDTH`, 32, payload bits per beat.
- `c_ID_WIDTH`, 2, source-ID field width; must satisfy 2^`c_ID_WIDTH` ≥ `c_NUM_REQ`.
- `c_MAX_BEATS`, 256, maximum beats per packet before truncation (2–65535).
- Derived: `c_FIFO_DATA_WIDTH` = `c_DATA_WIDTH`+`c_ID_WIDTH`+1. The FIFO's `c_WR_DATA_WIDTH` must equal it.

Ports:
- `clk` in 1: the single clock, tied to FIFO `wr_clk`. One clock; reset is synchronous and active-high.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in `c_NUM_REQ`: per-requester beat valid.
- `req_data` in `c_NUM_REQ`*`c_DATA_WIDTH`: requester i occupies bits [i*`c_DATA_WIDTH` +: `c_DATA_WIDTH`].
- `req_last` in `c_NUM_REQ`: final beat of the packet.
- `req_ready` out `c_NUM_REQ`: beat accepted when valid&ready.
- `fifo_wr_data` out `c_FIFO_DATA_WIDTH`: {last, id, payload}, last in the MSB.
- `fifo_wr_en` out 1: to FIFO `wr_en`.
- `fifo_wr_full` in 1: from FIFO `wr_full`.
- `fifo_almost_full` in 1: from FIFO `almost_full`.
- `grant_id` out `c_ID_WIDTH`: currently or last granted requester.
- `busy` out 1: high in XFER or DRAIN.
- `trunc_err` out 1: one-cycle pulse per truncated packet.

## Operation
States: IDLE, XFER, DRAIN.
- **IDLE**
  - All `req_ready`=0 and `fifo_wr_en`=0.
  - If any `req_valid` is high and `fifo_almost_full`=0, choose a winner round-robin, searching upward from `rr_ptr`+1 with wrap.
  - On that edge, register `grant_id`=winner, set `rr_ptr`=winner, clear `beat_cnt`, and go to XFER.
  - `fifo_almost_full`=1 blocks new grants only; it never interrupts a packet already in progress.
- **XFER**
  - `req_ready[g]`=~`fifo_wr_full`; all other requesters see ready=0.
  - `fifo_wr_en`=`req_valid[g]` & ~`fifo_wr_full`.
  - `fifo_wr_data`={`req_last[g]`|trunc, g, payload[g]}.
  - Each accepted beat increments `beat_cnt` (16-bit, saturates at `c_MAX_BEATS`).
  - Accepted beat with last=1 → IDLE.
  - Accepted beat number `c_MAX_BEATS` with last=0 → the written last bit is forced to 1, `trunc_err` pulses on the next cycle, and the state goes to DRAIN.
  - If `req_valid[g]` drops mid-packet, the grant is held indefinitely.
- **DRAIN**
  - `req_ready[g]`=1 and `fifo_wr_en`=0; incoming beats are discarded.
  - Accepted beat with last=1 → IDLE.
- **Reset**
  - State=IDLE, `rr_ptr`=`c_NUM_REQ`-1 (requester 0 wins first), `beat_cnt`=0.
  - Outputs: `grant_id`=0, `busy`=0, `trunc_err`=0, `fifo_wr_en`=0, `req_ready`=0.
  - Reset mid-packet abandons the packet immediately. FIFO contents are cleared only by the FIFO's own reset; the two resets are driven together.

## Timing
- Arbitration latency: a request seen in IDLE at edge N gets `req_ready` in the cycle after edge N. There is always at least one idle cycle between packets.
- Beat path is combinational and has zero latency: `req_valid`/`fifo_wr_full` → `fifo_wr_en`/`req_ready` in the same cycle. `fifo_wr_full` is the FIFO's registered flag.
- Sustained throughput in XFER is one beat per cycle while `fifo_wr_full`=0.
- `fifo_wr_full` asserting mid-packet stalls that beat; the grant and `beat_cnt` hold.
- Simultaneous last beat and `beat_cnt` reaching `c_MAX_BEATS`: treated as a normal end of packet, with no `trunc_err`.
- `grant_id` and `busy` are registered, updating on the edge that enters or leaves a state.

## Structure
- Package `hsst2ad_arb_pkg` holds:
  - state enum `arb_state_t` (IDLE=2'd0, XFER=2'd1, DRAIN=2'd2);
  - field offsets: `LAST_BIT`=`c_FIFO_DATA_WIDTH`-1, ID LSB=`c_DATA_WIDTH`;
  - the `c_FIFO_DATA_WIDTH` derivation function.
- Sub-module `hsst2ad_rr_picker`: combinational rotate → priority-encode → rotate-back winner select. It takes the valid vector and pointer and returns winner index and `any_valid`.

## Test plan
- **Single packet:** req 1 sends 4 beats (0xA0..0xA3, last on the 4th) into an empty FIFO → `req_ready[1]` rises one cycle after valid; 4 FIFO writes; MSB set only on 0xA3; ID=1 on every beat.
- **Fairness:** all 4 requesters continuously send 2-beat packets → grant order 0,1,2,3,0,… with one idle cycle between packets.
- **Backpressure:** `fifo_wr_full`=1 for 3 cycles at beat 2 of a 5-beat packet → `fifo_wr_en`=0 during those 3 cycles, no beat lost or duplicated, packet finishes after the stall.
- **Almost-full gating:** `fifo_almost_full`=1 while idle with req 2 valid → no grant until it drops; then grant 2 on the next cycle. Almost-full asserting mid-packet does not stop the packet.
- **Truncation:** `c_MAX_BEATS`=8, req 0 sends 12 beats → 8 beats written, the 8th with last=1; `trunc_err` pulses once; beats 9–12 accepted and dropped; back to IDLE.
- **Reset mid-packet:** `rst` asserted at beat 3 → the next cycle shows all outputs at reset values; after release, requester 0 has priority.

Source files
------------

// File: rtl/hsst2ad_arb_pkg.sv
// hsst2ad_arb_pkg: shared state encoding and FIFO word layout helpers for the hsst2ad write arbiter
package hsst2ad_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, DRAIN = 2'd2} arb_state_t;
  function automatic int fifo_data_width(input int data_w, input int id_w);
    return data_w + id_w + 1;
  endfunction
  function automatic int last_bit(input int data_w, input int id_w);
    return fifo_data_width(data_w, id_w) - 1;
  endfunction
  function automatic int id_lsb(input int data_w);
    return data_w;
  endfunction
endpackage

// File: rtl/hsst2ad_rr_picker.sv
// hsst2ad_rr_picker: combinational round-robin winner select, searching upward from ptr+1 with wrap
//   valid     : request vector
//   ptr       : last winner
//   winner    : first valid index after ptr
//   any_valid : at least one request pending
module hsst2ad_rr_picker #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] winner,
  output logic          any_valid
);
  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  int             k;
  always_comb begin
    dbl = {valid, valid} >> (int'(ptr) + 1);
    rot = dbl[N-1:0];
    k = 0;
    for (int i = N - 1; i >= 0; i--) if (rot[i]) k = i;
    winner = IW'((int'(ptr) + 1 + k) % N);
  end
  assign any_valid = |valid;
endmodule

// File: rtl/hsst2ad_fifo_wr_arb.sv
// hsst2ad_fifo_wr_arb: packet-granular round-robin arbiter sharing the hsst2ad FIFO write port
//   req_valid/req_data/req_last/req_ready : per-requester beat handshake
//   fifo_wr_data/fifo_wr_en               : {last, id, payload} write to the FIFO
//   fifo_wr_full/fifo_almost_full         : FIFO flags (full stalls beats, almost-full blocks new grants)
//   grant_id/busy/trunc_err               : status
module hsst2ad_fifo_wr_arb
  import hsst2ad_arb_pkg::*;
#(
  parameter int c_NUM_REQ         = 4,
  parameter int c_DATA_WIDTH      = 32,
  parameter int c_ID_WIDTH        = 2,
  parameter int c_MAX_BEATS       = 256,
  parameter int c_FIFO_DATA_WIDTH = fifo_data_width(c_DATA_WIDTH, c_ID_WIDTH)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [c_NUM_REQ-1:0]              req_valid,
  input  logic [c_NUM_REQ*c_DATA_WIDTH-1:0] req_data,
  input  logic [c_NUM_REQ-1:0]              req_last,
  output logic [c_NUM_REQ-1:0]              req_ready,
  output logic [c_FIFO_DATA_WIDTH-1:0]      fifo_wr_data,
  output logic                              fifo_wr_en,
  input  logic                              fifo_wr_full,
  input  logic                              fifo_almost_full,
  output logic [c_ID_WIDTH-1:0]             grant_id,
  output logic                              busy,
  output logic                              trunc_err
);
  localparam int LAST_BIT = last_bit(c_DATA_WIDTH, c_ID_WIDTH);
  localparam int ID_LSB   = id_lsb(c_DATA_WIDTH);
  arb_state_t              state, state_nx;
  logic [c_ID_WIDTH-1:0]   rr_ptr, winner;
  logic [15:0]             beat_cnt, cnt_inc;
  logic                    any_valid, sel_valid, sel_last, at_max, trunc_nx;
  logic [c_DATA_WIDTH-1:0] sel_data;
  hsst2ad_rr_picker #(.N(c_NUM_REQ), .IW(c_ID_WIDTH)) u_picker (
    .valid(req_valid),
    .ptr(rr_ptr),
    .winner(winner),
    .any_valid(any_valid)
  );
  assign sel_valid = req_valid[grant_id];
  assign sel_last  = req_last[grant_id];
  assign sel_data  = req_data[grant_id*c_DATA_WIDTH +: c_DATA_WIDTH];
  // the beat being offered is number c_MAX_BEATS of the packet
  assign at_max    = beat_cnt == 16'(c_MAX_BEATS - 1);
  assign cnt_inc   = beat_cnt == 16'(c_MAX_BEATS) ? beat_cnt : beat_cnt + 16'd1;
  always_comb begin
    fifo_wr_data = '0;
    fifo_wr_data[LAST_BIT] = sel_last | at_max;
    fifo_wr_data[ID_LSB +: c_ID_WIDTH] = grant_id;
    fifo_wr_data[c_DATA_WIDTH-1:0] = sel_data;
  end
  always_comb begin
    state_nx = state;
    trunc_nx = 1'b0;
    req_ready = '0;
    fifo_wr_en = 1'b0;
    case (state)
      IDLE: if (any_valid && !fifo_almost_full) state_nx = XFER;
      XFER: begin
        req_ready[grant_id] = ~fifo_wr_full;
        fifo_wr_en = sel_valid & ~fifo_wr_full;
        if (fifo_wr_en && sel_last) state_nx = IDLE;
        else if (fifo_wr_en && at_max) begin
          state_nx = DRAIN;
          trunc_nx = 1'b1;
        end
      end
      DRAIN: begin
        req_ready[grant_id] = 1'b1;
        if (sel_valid && sel_last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= c_ID_WIDTH'(c_NUM_REQ - 1);
      grant_id  <= '0;
      beat_cnt  <= '0;
      busy      <= 1'b0;
      trunc_err <= 1'b0;
    end else begin
      state     <= state_nx;
      busy      <= state_nx != IDLE;
      trunc_err <= trunc_nx;
      if (state == IDLE && state_nx == XFER) begin
        grant_id <= winner;
        rr_ptr   <= winner;
        beat_cnt <= '0;
      end else if (fifo_wr_en) beat_cnt <= cnt_inc;
    end
  end
endmodule
